multicycle_main_control: RTL
============================

// Module: multicycle_main_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback per opcode.
//  Drives alu_op[1:0] into alu_control, plus the mux selects and write enables for PC, IR, memory and register file.
//  Stalls on a memory ready handshake and counts retired instructions.
// PARAMETERS
//  CNT_W      32         width of retired-instruction counter
//  OP_RTYPE   6'b000000  R-type opcode
//  OP_LW      6'b100011  load word
//  OP_SW      6'b101011  store word
//  OP_BEQ     6'b000100  branch if equal
//  OP_J       6'b000010  jump
//  OP_ADDI    6'b001000  add immediate
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      synchronous, active-high
//  opcode         in   6      IR[31:26], valid from DECODE onward
//  zero           in   1      ALU zero flag
//  mem_ready      in   1      memory completes the access this cycle
//  pc_write       out  1      unconditional PC write
//  pc_write_cond  out  1      PC write if zero
//  pc_en          out  1      pc_write | (pc_write_cond & zero)
//  i_or_d         out  1      memory address: 0=PC, 1=ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  ir_write       out  1      latch instruction register
//  mem_to_reg     out  1      RF write data: 0=ALUOut, 1=MDR
//  reg_dst        out  1      RF dest: 0=rt, 1=rd
//  reg_write      out  1      RF write enable
//  alu_src_a      out  1      0=PC, 1=A
//  alu_src_b      out  2      00=B, 01=4, 10=signext, 11=signext<<2
//  alu_op         out  2      to alu_control: 00 add, 01 sub, 10 funct
//  pc_source      out  2      00=ALU, 01=ALUOut, 10=jump target
//  illegal_op     out  1      1-cycle pulse on unknown opcode
//  state          out  4      current state code (debug)
//  instr_count    out  CNT_W  retired instructions
// BEHAVIOUR
//  - Clock and reset: one clock, clk. reset is synchronous and active-high.
//  - Reset effects:
//    - state<=FETCH and instr_count<=0.
//    - While reset=1, pc_write, pc_en, ir_write, reg_write, mem_write and illegal_op are forced 0.
//    - A reset asserted mid-instruction aborts it and leaves no partial writeback.
//  - Output timing:
//    - Outputs are decoded combinationally from state; signals not listed for a state are 0.
//    - ir_write and the FETCH pc_write also depend on mem_ready.
//  - States and transitions (4-bit codes):
//    - 0 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//      ir_write=pc_write=mem_ready. Stay while !mem_ready, else go to DECODE.
//    - 1 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
//      LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDI_EX.
//      Any other opcode->FETCH with illegal_op=1 this cycle; not counted as retired.
//    - 2 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW->MEMRD, SW->MEMWR.
//    - 3 MEMRD: mem_read=1, i_or_d=1. Wait for mem_ready, then MEMWB.
//    - 4 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
//    - 5 MEMWR: mem_write=1, i_or_d=1. Wait for mem_ready, then FETCH.
//    - 6 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB.
//    - 7 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
//    - 8 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, then FETCH.
//    - 9 JUMP: pc_source=10, pc_write=1, then FETCH.
//    - 10 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDI_WB.
//    - 11 ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
//    - Codes 12-15: all outputs 0, next state FETCH.
//  - Retired-instruction counter:
//    - instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDI_WB.
//    - It wraps modulo 2^CNT_W.
//  - Latency with mem_ready=1 every cycle: R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4 cycles.
//    Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
//  - opcode must remain stable from DECODE until the return to FETCH (IR is held; ir_write=0).
// TESTING
//  - Reset: reset=1 for 2 clk, then reset=0 with mem_ready=0.
//    -> state=0, instr_count=0, mem_read=1, ir_write=0, pc_en=0.
//  - R-type: opcode=000000, mem_ready=1.
//    -> states 0,1,6,7,0; alu_op=10 in EXEC; reg_write=1 with reg_dst=1 in ALUWB; instr_count=1.
//  - LW with stalls: opcode=100011, mem_ready=0 for 3 cycles in MEMRD.
//    -> 8 cycles total; mem_read=1 with i_or_d=1 throughout MEMRD; mem_to_reg=1 in MEMWB.
//  - BEQ: opcode=000100 with zero=1, then again with zero=0.
//    -> pc_en=1 in BRANCH, then pc_en=0; alu_op=01 both times; pc_source=01.
//  - Illegal opcode: opcode=111111.
//    -> illegal_op=1 for 1 cycle in DECODE; return to FETCH; instr_count unchanged.
//  - Reset mid-op: reset=1 during MEMWR with mem_ready=0.
//    -> mem_write=0 immediately, state=0 next cycle, instr_count=0.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback per opcode, stalls on
// mem_ready and counts retired instructions.
module multicycle_main_control #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010,
  parameter logic [5:0]  OP_ADDI  = 6'b001000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire;

  assign state = state_q;

  // State register and retired-instruction counter; reset aborts any
  // in-flight instruction so its retirement is never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state and Moore-style control decode; write strobes are masked
  // while reset is held so no partial writeback escapes.
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  // PC enable combines the unconditional and zero-qualified write requests.
  always_comb begin
    pc_en = pc_write | (pc_write_cond & zero & ~reset);
  end

endmodule
